divider_8bit: RTL and testbench

DIVIDER_8BIT -- requirements
Module: divider_8bit

---
 rtl/divider_8bit.sv | 128 ++++++++++++
 tb/tb_divider_8bit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_8bit.sv
// divider_8bit: 8-bit unsigned restoring shift-subtract divider.
// It produces one quotient bit per clock, so a result takes 8 cycles after start.
`default_nettype none

module divider_8bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  dvd_q, dvd_nxt;      // dividend bits shift out MSB first, quotient bits shift in
   logic [7:0]  dvs_q, dvs_nxt;
   logic [8:0]  part_q, part_nxt;
   logic [3:0]  cnt_q, cnt_nxt;
   logic        zero_pend_q, zero_pend_nxt;
   logic [7:0]  quo_nxt, rem_nxt;
   logic        busy_nxt, done_nxt, dz_nxt;

   logic [8:0]  shifted;
   logic [9:0]  trial;
   logic        no_borrow;
   logic [8:0]  part_step;

   always_comb begin
      shifted   = {part_q[7:0], dvd_q[7]};
      trial     = {1'b0, shifted} - {2'b00, dvs_q};
      no_borrow = ~trial[9];
      part_step = no_borrow ? trial[8:0] : shifted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dvd_q       <= 8'h00;
         dvs_q       <= 8'h00;
         part_q      <= 9'h000;
         cnt_q       <= 4'h0;
         zero_pend_q <= 1'b0;
         quotient    <= 8'h00;
         remainder   <= 8'h00;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         dvd_q       <= dvd_nxt;
         dvs_q       <= dvs_nxt;
         part_q      <= part_nxt;
         cnt_q       <= cnt_nxt;
         zero_pend_q <= zero_pend_nxt;
         quotient    <= quo_nxt;
         remainder   <= rem_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         div_by_zero <= dz_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      dvd_nxt       = dvd_q;
      dvs_nxt       = dvs_q;
      part_nxt      = part_q;
      cnt_nxt       = cnt_q;
      zero_pend_nxt = zero_pend_q;
      quo_nxt       = quotient;
      rem_nxt       = remainder;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      dz_nxt        = div_by_zero;

      case (state)
         IDLE: begin
            if (zero_pend_q) begin
               // Zero divisor: report one edge after acceptance, start stays ignored meanwhile.
               zero_pend_nxt = 1'b0;
               quo_nxt       = 8'hFF;
               rem_nxt       = dvd_q;
               dz_nxt        = 1'b1;
               done_nxt      = 1'b1;
               busy_nxt      = 1'b0;
            end else if (start) begin
               dvd_nxt  = dividend;
               dvs_nxt  = divisor;
               part_nxt = 9'h000;
               cnt_nxt  = 4'h0;
               busy_nxt = 1'b1;
               if (divisor == 8'h00)
                  zero_pend_nxt = 1'b1;
               else
                  state_nxt = RUN;
            end
         end

         RUN: begin
            part_nxt = part_step;
            dvd_nxt  = {dvd_q[6:0], no_borrow};
            cnt_nxt  = cnt_q + 4'h1;
            if (cnt_q == 4'h7) begin
               quo_nxt   = {dvd_q[6:0], no_borrow};
               rem_nxt   = part_step[7:0];
               dz_nxt    = 1'b0;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_divider_8bit.sv
// tb_divider_8bit: directed and random self-checking bench for divider_8bit.
`default_nettype none

module tb_divider_8bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int vectors;
   int miscompares;

   divider_8bit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive start now; the next rising edge is E0. Returns #1 after E0.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input string name);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s E0: busy=%b done=%b, required busy=1 done=0", name, busy, done);
      end
   endtask

   // Waits for done, checking outputs hold and busy stays high until then.
   task automatic wait_result(input logic [7:0] eq, input logic [7:0] er, input logic edz,
                              input int elat, input string name);
      logic [7:0] hq, hr;
      logic       hdz;
      int         n;
      bit         got;
      hq = quotient; hr = remainder; hdz = div_by_zero;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (done === 1'b1) got = 1;
         else begin
            vectors++;
            if (busy !== 1'b1 || quotient !== hq || remainder !== hr || div_by_zero !== hdz) begin
               miscompares++;
               $display("FAIL %s hold@%0d: busy=%b q=%0d r=%0d dz=%b, required busy=1 q=%0d r=%0d dz=%b",
                        name, n, busy, quotient, remainder, div_by_zero, hq, hr, hdz);
            end
         end
      end
      vectors++;
      if (!got || n != elat) begin
         miscompares++;
         $display("FAIL %s latency: got done=%0d after %0d edges, required %0d", name, got, n, elat);
      end
      vectors++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s result: q=%0d r=%0d dz=%b busy=%b, required q=%0d r=%0d dz=%b busy=0",
                  name, quotient, remainder, div_by_zero, busy, eq, er, edz);
      end
   endtask

   task automatic done_clears(input string name);
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s pulse: done=%b busy=%b, required done=0 busy=0", name, done, busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
      #3;
      vectors++;
      if (quotient !== 8'h00 || remainder !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: q=%0d r=%0d busy=%b done=%b dz=%b, required all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      launch(8'd100, 8'd7, "100/7");
      wait_result(8'd14, 8'd2, 1'b0, 8, "100/7");
      done_clears("100/7");
   endtask

   task automatic test_boundaries;
      launch(8'd255, 8'd1, "255/1");   wait_result(8'd255, 8'd0, 1'b0, 8, "255/1");  done_clears("255/1");
      launch(8'd5, 8'd10, "5/10");     wait_result(8'd0, 8'd5, 1'b0, 8, "5/10");     done_clears("5/10");
      launch(8'd0, 8'd3, "0/3");       wait_result(8'd0, 8'd0, 1'b0, 8, "0/3");      done_clears("0/3");
      launch(8'd255, 8'd255, "255/255"); wait_result(8'd1, 8'd0, 1'b0, 8, "255/255"); done_clears("255/255");
   endtask

   task automatic test_div_by_zero;
      launch(8'd200, 8'd0, "200/0");
      wait_result(8'hFF, 8'd200, 1'b1, 1, "200/0");
      done_clears("200/0");
      launch(8'd100, 8'd7, "100/7 after zero");
      wait_result(8'd14, 8'd2, 1'b0, 8, "100/7 after zero");
      done_clears("100/7 after zero");
   endtask

   task automatic test_back_to_back;
      launch(8'd100, 8'd7, "ignore");
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_result(8'd14, 8'd2, 1'b0, 5, "ignore");
      launch(8'd50, 8'd5, "done-cycle start");
      wait_result(8'd10, 8'd0, 1'b0, 8, "done-cycle start");
      done_clears("done-cycle start");
   endtask

   task automatic test_reset_abort;
      int n;
      bit seen;
      launch(8'd100, 8'd7, "abort");
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (quotient !== 8'h00 || remainder !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL abort reset: q=%0d r=%0d busy=%b done=%b dz=%b, required all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0; seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL abort no-done: activity seen after aborted division, required done=0 busy=0");
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      launch(8'd9, 8'd2, "9/2 after reset");
      wait_result(8'd4, 8'd1, 1'b0, 8, "9/2 after reset");
      done_clears("9/2 after reset");
   endtask

   task automatic test_random;
      logic [7:0] a, b;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom_range(255, 0));
         b = 8'($urandom_range(255, 1));
         launch(a, b, "random");
         wait_result(a / b, a % b, 1'b0, 8, "random");
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset;
      test_basic;
      test_boundaries;
      test_div_by_zero;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
